// File: rtl/program_run_controller_if.sv
// Load-stream, instruction-memory write and data-store snoop bundle for
// program_run_controller. The slave modport is the controller's view; the
// master modport is the view of whatever feeds the image and owns the core.
interface program_run_controller_if #(
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
);
    // program image stream
    logic                 LOAD_VALID;
    logic                 LOAD_READY;
    logic [DATA_SIZE-1:0] LOAD_DATA;
    logic                 LOAD_LAST;
    // instruction-memory write port
    logic                 IMEM_WE;
    logic [ADDR_SIZE-1:0] IMEM_WADDR;
    logic [DATA_SIZE-1:0] IMEM_WDATA;
    // snooped core data-memory store bus
    logic [ADDR_SIZE-1:0] daddr;
    logic                 MemWrite;
    logic [DATA_SIZE-1:0] ddata_w;

    modport master (
        output LOAD_VALID, LOAD_DATA, LOAD_LAST, daddr, MemWrite, ddata_w,
        input  LOAD_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA
    );

    modport slave (
        input  LOAD_VALID, LOAD_DATA, LOAD_LAST, daddr, MemWrite, ddata_w,
        output LOAD_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA
    );
endinterface

// File: rtl/program_run_controller.sv
// Run controller for the pipelined RISC-V core: streams a program image into
// instruction memory while holding the core in reset, releases the core, then
// watches data stores for the tohost write, counting RUN cycles and enforcing
// a timeout. DONE/PASS/TIMEOUT/CYCLES/RESULT stay put until START or RESET.
// Optional feature macro: RUN_STORE_COUNT_EN adds a saturating STORES count of
// MemWrite cycles seen in RUN.
module program_run_controller #(
    parameter int                   ADDR_SIZE      = 10,
    parameter int                   DATA_SIZE      = 32,
    parameter logic [ADDR_SIZE-1:0] TOHOST_ADDR    = 10'h3FF,
    parameter int                   TIMEOUT_CYCLES = 1000,
    parameter int                   CNT_WIDTH      = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    program_run_controller_if.slave  bus,
    output logic                     CORE_RESET_N,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     PASS,
    output logic                     TIMEOUT,
    output logic [CNT_WIDTH-1:0]     CYCLES,
    output logic [DATA_SIZE-1:0]     RESULT
`ifdef RUN_STORE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     STORES
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_END  = 2'd3
    } state_e;

    localparam logic [ADDR_SIZE-1:0] PTR_MAX      = {ADDR_SIZE{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
    // CYCLES value seen during the last permitted RUN cycle
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_SIZE-1:0] PASS_VALUE   = DATA_SIZE'(1);

    // Counter step that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
    logic                 load_ready_q, load_ready_d;
    logic                 core_reset_n_q, core_reset_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
`ifdef RUN_STORE_COUNT_EN
    logic [CNT_WIDTH-1:0] stores_q, stores_d;
`endif

    logic accept_s;
    logic store_hit_s;
    logic timeout_hit_s;

    // Qualify the load handshake and classify the snooped store this cycle.
    always_comb begin
        accept_s      = bus.LOAD_VALID & load_ready_q;
        store_hit_s   = bus.MemWrite & (bus.daddr == TOHOST_ADDR);
        timeout_hit_s = (cycles_q == TIMEOUT_LAST);
    end

    // Instruction-memory write port follows the accepted load beat; quiet otherwise.
    always_comb begin
        bus.IMEM_WE    = 1'b0;
        bus.IMEM_WADDR = {ADDR_SIZE{1'b0}};
        bus.IMEM_WDATA = {DATA_SIZE{1'b0}};
        if (load_ready_q) begin
            bus.IMEM_WE    = accept_s;
            bus.IMEM_WADDR = ptr_q;
            bus.IMEM_WDATA = bus.LOAD_DATA;
        end else begin
            bus.IMEM_WE    = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/LOAD/RUN/END sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        result_d  = result_q;
`ifdef RUN_STORE_COUNT_EN
        stores_d  = stores_q;
`endif

        case (state_q)
            ST_IDLE, ST_END: begin
                // START here begins a fresh run; results from the old one are dropped
                if (START) begin
                    state_d   = ST_LOAD;
                    ptr_d     = {ADDR_SIZE{1'b0}};
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    cycles_d  = {CNT_WIDTH{1'b0}};
                    result_d  = {DATA_SIZE{1'b0}};
`ifdef RUN_STORE_COUNT_EN
                    stores_d  = {CNT_WIDTH{1'b0}};
`endif
                end else begin
                    state_d = state_q;
                end
            end

            ST_LOAD: begin
                if (accept_s) begin
                    // the pointer parks on the last word instead of wrapping
                    if (ptr_q == PTR_MAX) begin
                        ptr_d   = ptr_q;
                        state_d = ST_RUN;
                    end else if (bus.LOAD_LAST) begin
                        ptr_d   = ptr_q + ADDR_SIZE'(1);
                        state_d = ST_RUN;
                    end else begin
                        ptr_d   = ptr_q + ADDR_SIZE'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_RUN: begin
                cycles_d = sat_inc(cycles_q);
`ifdef RUN_STORE_COUNT_EN
                if (bus.MemWrite) begin
                    stores_d = sat_inc(stores_q);
                end else begin
                    stores_d = stores_q;
                end
`endif
                // a tohost store outranks a coincident timeout
                if (store_hit_s) begin
                    result_d = bus.ddata_w;
                    pass_d   = (bus.ddata_w == PASS_VALUE);
                    done_d   = 1'b1;
                    state_d  = ST_END;
                end else if (timeout_hit_s) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_END;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // the core leaves reset one edge after RUN starts and re-enters it one
        // edge after RUN ends, so it always sees a full registered release
        core_reset_n_d = (state_q == ST_RUN);
        load_ready_d   = (state_d == ST_LOAD);
        busy_d         = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    // State and output registers with synchronous reset overriding everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            ptr_q          <= {ADDR_SIZE{1'b0}};
            load_ready_q   <= 1'b0;
            core_reset_n_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
            cycles_q       <= {CNT_WIDTH{1'b0}};
            result_q       <= {DATA_SIZE{1'b0}};
`ifdef RUN_STORE_COUNT_EN
            stores_q       <= {CNT_WIDTH{1'b0}};
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            load_ready_q   <= load_ready_d;
            core_reset_n_q <= core_reset_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_q      <= timeout_d;
            cycles_q       <= cycles_d;
            result_q       <= result_d;
`ifdef RUN_STORE_COUNT_EN
            stores_q       <= stores_d;
`endif
        end
    end

    assign bus.LOAD_READY = load_ready_q;
    assign CORE_RESET_N   = core_reset_n_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign TIMEOUT        = timeout_q;
    assign CYCLES         = cycles_q;
    assign RESULT         = result_q;
`ifdef RUN_STORE_COUNT_EN
    assign STORES         = stores_q;
`endif

endmodule

// File: tb/tb_program_run_controller.sv
// Scoreboard bench for program_run_controller. dut_a uses 10-bit addresses and
// a 50-cycle timeout; dut_b uses 3-bit addresses (8-word image) and a 10-cycle
// timeout. Stimulus pushes expected IMEM writes and run results into queues;
// negedge monitors pop and compare whenever a DUT writes IMEM or raises DONE.
module tb_program_run_controller;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [31:0] res;
        logic [31:0] cyc;
    } dn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        crn_a, busy_a, done_a, pass_a, tmo_a;
    logic        crn_b, busy_b, done_b, pass_b, tmo_b;
    logic [31:0] cyc_a, res_a, cyc_b, res_b;
`ifdef RUN_STORE_COUNT_EN
    logic [31:0] stores_a, stores_b;
`endif

    int total = 0;
    int bad   = 0;

    wr_t wq_a[$];
    wr_t wq_b[$];
    dn_t dq_a[$];
    dn_t dq_b[$];

    logic done_prev_a = 1'b0;
    logic done_prev_b = 1'b0;
    logic crn_chk_a   = 1'b0;
    logic crn_chk_b   = 1'b0;

    program_run_controller_if #(.ADDR_SIZE(10), .DATA_SIZE(32)) ifa ();
    program_run_controller_if #(.ADDR_SIZE(3),  .DATA_SIZE(32)) ifb ();

    program_run_controller #(
        .ADDR_SIZE(10), .DATA_SIZE(32), .TOHOST_ADDR(10'h3FF),
        .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)
    ) dut_a (
        .CLK(clk), .RESET(rst), .START(start_a), .bus(ifa),
        .CORE_RESET_N(crn_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
        .TIMEOUT(tmo_a), .CYCLES(cyc_a), .RESULT(res_a)
`ifdef RUN_STORE_COUNT_EN
        , .STORES(stores_a)
`endif
    );

    program_run_controller #(
        .ADDR_SIZE(3), .DATA_SIZE(32), .TOHOST_ADDR(3'h7),
        .TIMEOUT_CYCLES(10), .CNT_WIDTH(32)
    ) dut_b (
        .CLK(clk), .RESET(rst), .START(start_b), .bus(ifb),
        .CORE_RESET_N(crn_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
        .TIMEOUT(tmo_b), .CYCLES(cyc_b), .RESULT(res_b)
`ifdef RUN_STORE_COUNT_EN
        , .STORES(stores_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor for dut_a: IMEM writes and DONE rising edges against the queues.
    always @(negedge clk) begin
        if (crn_chk_a) chk("a_crn_low_after_done", 64'(crn_a), 64'd0);
        if (ifa.IMEM_WE) begin
            if (wq_a.size() == 0) begin
                chk("a_imem_extra", 64'(wq_a.size()), 64'd1);
            end else begin
                chk("a_imem_addr", 64'(ifa.IMEM_WADDR), 64'(wq_a[0].addr));
                chk("a_imem_data", 64'(ifa.IMEM_WDATA), 64'(wq_a[0].data));
                void'(wq_a.pop_front());
            end
        end
        if (done_a && !done_prev_a) begin
            if (dq_a.size() == 0) begin
                chk("a_done_extra", 64'(dq_a.size()), 64'd1);
            end else begin
                chk("a_pass",    64'(pass_a), 64'(dq_a[0].pass));
                chk("a_timeout", 64'(tmo_a),  64'(dq_a[0].tmo));
                chk("a_result",  64'(res_a),  64'(dq_a[0].res));
                chk("a_cycles",  64'(cyc_a),  64'(dq_a[0].cyc));
                chk("a_crn_high_at_done", 64'(crn_a), 64'd1);
                void'(dq_a.pop_front());
            end
        end
        done_prev_a <= done_a;
        crn_chk_a   <= done_a && !done_prev_a;
    end

    // Monitor for dut_b: IMEM writes and DONE rising edges against the queues.
    always @(negedge clk) begin
        if (crn_chk_b) chk("b_crn_low_after_done", 64'(crn_b), 64'd0);
        if (ifb.IMEM_WE) begin
            if (wq_b.size() == 0) begin
                chk("b_imem_extra", 64'(wq_b.size()), 64'd1);
            end else begin
                chk("b_imem_addr", 64'(ifb.IMEM_WADDR), 64'(wq_b[0].addr));
                chk("b_imem_data", 64'(ifb.IMEM_WDATA), 64'(wq_b[0].data));
                void'(wq_b.pop_front());
            end
        end
        if (done_b && !done_prev_b) begin
            if (dq_b.size() == 0) begin
                chk("b_done_extra", 64'(dq_b.size()), 64'd1);
            end else begin
                chk("b_pass",    64'(pass_b), 64'(dq_b[0].pass));
                chk("b_timeout", 64'(tmo_b),  64'(dq_b[0].tmo));
                chk("b_result",  64'(res_b),  64'(dq_b[0].res));
                chk("b_cycles",  64'(cyc_b),  64'(dq_b[0].cyc));
                chk("b_crn_high_at_done", 64'(crn_b), 64'd1);
                void'(dq_b.pop_front());
            end
        end
        done_prev_b <= done_b;
        crn_chk_b   <= done_b && !done_prev_b;
    end

    // Hard stop if something hangs beyond any bounded wait.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Stream n words into dut_a; LAST on the final one if asked; 3-cycle stall after word stall_after.
    task automatic load_a(input int n, input logic [31:0] base, input logic use_last, input int stall_after);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            wq_a.push_back({32'(i), base + 32'(i)});
            ifa.LOAD_VALID = 1'b1;
            ifa.LOAD_DATA  = base + 32'(i);
            ifa.LOAD_LAST  = use_last && (i == n - 1);
            @(negedge clk);
            while (!ifa.LOAD_READY && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("a_load_ready", 64'(ifa.LOAD_READY), 64'd1);
            @(posedge clk); #1;
            ifa.LOAD_VALID = 1'b0;
            ifa.LOAD_LAST  = 1'b0;
            if (i == stall_after) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic store_a(input logic [9:0] addr, input logic [31:0] data);
        ifa.MemWrite = 1'b1;
        ifa.daddr    = addr;
        ifa.ddata_w  = data;
        @(posedge clk); #1;
        ifa.MemWrite = 1'b0;
    endtask

    // Bounded wait for DONE on either DUT, then step to just after the next edge.
    task automatic wait_done(input logic use_b, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!(use_b ? done_b : done_a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(use_b ? "b_done_wait" : "a_done_wait", 64'(use_b ? done_b : done_a), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        // busy inputs during reset and IDLE must not leak into IMEM or results
        ifa.LOAD_VALID = 1'b1; ifa.LOAD_DATA = 32'hA5A5_A5A5; ifa.LOAD_LAST = 1'b0;
        ifa.daddr = 10'h3FF; ifa.MemWrite = 1'b1; ifa.ddata_w = 32'd1;
        ifb.LOAD_VALID = 1'b0; ifb.LOAD_DATA = 32'd0; ifb.LOAD_LAST = 1'b0;
        ifb.daddr = 3'h0; ifb.MemWrite = 1'b0; ifb.ddata_w = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_crn",    64'(crn_a),  64'd0);
        chk("rst_busy",   64'(busy_a), 64'd0);
        chk("rst_done",   64'(done_a), 64'd0);
        chk("rst_pass",   64'(pass_a), 64'd0);
        chk("rst_tmo",    64'(tmo_a),  64'd0);
        chk("rst_cycles", 64'(cyc_a),  64'd0);
        chk("rst_result", 64'(res_a),  64'd0);
        chk("rst_ready",  64'(ifa.LOAD_READY), 64'd0);
        chk("rst_b_crn",  64'(crn_b),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_ready", 64'(ifa.LOAD_READY), 64'd0);
        chk("idle_done",  64'(done_a), 64'd0);
        chk("idle_crn",   64'(crn_a),  64'd0);
        @(posedge clk); #1;
        ifa.LOAD_VALID = 1'b0; ifa.MemWrite = 1'b0;

        // Run 1: 4 words with a mid-stream stall, tohost=1 on RUN cycle 20
        pulse_start_a();
        load_a(4, 32'h0000_1000, 1'b1, 1);
        @(negedge clk);
        chk("run1_crn_cycle0", 64'(crn_a), 64'd0);
        chk("run1_cyc_cycle0", 64'(cyc_a), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("run1_crn_cycle1", 64'(crn_a),  64'd1);
        chk("run1_busy",       64'(busy_a), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        store_a(10'h100, 32'd1);            // RUN cycle 5, not tohost
        repeat (14) @(posedge clk);
        #1;
        dq_a.push_back({1'b1, 1'b0, 32'd1, 32'd21});
        store_a(10'h3FF, 32'd1);            // RUN cycle 20
        wait_done(1'b0, 20);
        chk("run1_busy_end", 64'(busy_a), 64'd0);

        // Run 2: restart from END; three stray stores, START mid-run, tohost=5
        pulse_start_a();
        @(negedge clk);
        chk("run2_clr_done",   64'(done_a), 64'd0);
        chk("run2_clr_pass",   64'(pass_a), 64'd0);
        chk("run2_clr_result", 64'(res_a),  64'd0);
        chk("run2_clr_cycles", 64'(cyc_a),  64'd0);
        chk("run2_busy_load",  64'(busy_a), 64'd1);
        @(posedge clk); #1;
        load_a(2, 32'h0000_2000, 1'b1, -1);
        store_a(10'h010, 32'd1);            // cycle 0
        start_a = 1'b1;                     // START in RUN must be ignored
        store_a(10'h011, 32'd1);            // cycle 1
        start_a = 1'b0;
        store_a(10'h012, 32'd1);            // cycle 2
        dq_a.push_back({1'b0, 1'b0, 32'd5, 32'd4});
        store_a(10'h3FF, 32'd5);            // cycle 3
        wait_done(1'b0, 20);
`ifdef RUN_STORE_COUNT_EN
        chk("run2_stores", 64'(stores_a), 64'd4);
`endif

        // Run 3: no tohost store, times out after 50 RUN cycles
        pulse_start_a();
        load_a(1, 32'h0000_3000, 1'b1, -1);
        dq_a.push_back({1'b0, 1'b1, 32'd0, 32'd50});
        wait_done(1'b0, 100);

        // Run 4: RESET in the middle of RUN
        pulse_start_a();
        load_a(1, 32'h0000_4000, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_crn",    64'(crn_a),  64'd0);
        chk("mid_rst_busy",   64'(busy_a), 64'd0);
        chk("mid_rst_cycles", 64'(cyc_a),  64'd0);
        chk("mid_rst_ready",  64'(ifa.LOAD_READY), 64'd0);
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_idle_done", 64'(done_a), 64'd0);
        chk("mid_rst_idle_busy", 64'(busy_a), 64'd0);
        @(posedge clk); #1;

        // dut_b: 8-word image with no LAST fills memory; extra valid words ignored;
        // tohost store on the 10th RUN cycle collides with the timeout and wins
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wq_b.push_back({32'(i), 32'h100 + 32'(i)});
            ifb.LOAD_VALID = 1'b1;
            ifb.LOAD_DATA  = 32'h100 + 32'(i);
            @(negedge clk);
            chk("b_load_ready", 64'(ifb.LOAD_READY), 64'd1);
            @(posedge clk); #1;
        end
        ifb.LOAD_DATA = 32'h0000_DEAD;      // still valid: must not be written
        @(negedge clk);
        chk("b_ready_after_full", 64'(ifb.LOAD_READY), 64'd0);
        chk("b_busy_run",         64'(busy_b), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        ifb.LOAD_VALID = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        dq_b.push_back({1'b1, 1'b0, 32'd1, 32'd10});
        ifb.MemWrite = 1'b1; ifb.daddr = 3'h7; ifb.ddata_w = 32'd1;
        @(posedge clk); #1;
        ifb.MemWrite = 1'b0;
        wait_done(1'b1, 20);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_imem_q_left", 64'(wq_a.size()), 64'd0);
        chk("b_imem_q_left", 64'(wq_b.size()), 64'd0);
        chk("a_done_q_left", 64'(dq_a.size()), 64'd0);
        chk("b_done_q_left", 64'(dq_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
